// File: rtl/m_transmit_if.sv
// ============================================================================
// m_transmit_if : GMII-side inputs and code-group outputs of the PCS transmit block
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface m_transmit_if;
  logic [7:0]  i8_TxD;
  logic        i_TxEN;
  logic        i_TxER;
  logic [2:0]  i3_Xmit;
  logic [15:0] i16_TxConfigReg;
  logic        i_TxDisparity;
  logic [7:0]  o8_TxCodeGroup;
  logic        o_TxCodeCtrl;
  logic        o_TxEven;
  logic        o_Transmitting;

  modport slave (
    input  i8_TxD, i_TxEN, i_TxER, i3_Xmit, i16_TxConfigReg, i_TxDisparity,
    output o8_TxCodeGroup, o_TxCodeCtrl, o_TxEven, o_Transmitting
  );

  modport master (
    output i8_TxD, i_TxEN, i_TxER, i3_Xmit, i16_TxConfigReg, i_TxDisparity,
    input  o8_TxCodeGroup, o_TxCodeCtrl, o_TxEven, o_Transmitting
  );
endinterface

`default_nettype wire

// File: rtl/m_transmit.sv
// ============================================================================
// m_transmit : PCS transmit ordered-set generator (config, idle, packet, EPD)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module m_transmit (
  input  logic        i_Clk,
  input  logic        i_ARst_L,
  m_transmit_if.slave bus
);

  localparam logic [2:0] c_XMIT_CONFIG = 3'b001;
  localparam logic [2:0] c_XMIT_IDLE   = 3'b010;
  localparam logic [2:0] c_XMIT_DATA   = 3'b100;

  localparam logic [7:0] c_K28_5 = 8'hBC;
  localparam logic [7:0] c_D21_5 = 8'hB5;
  localparam logic [7:0] c_D2_2  = 8'h42;
  localparam logic [7:0] c_D5_6  = 8'hC5;
  localparam logic [7:0] c_D16_2 = 8'h50;
  localparam logic [7:0] c_SPD   = 8'hFB;
  localparam logic [7:0] c_EPD_T = 8'hFD;
  localparam logic [7:0] c_EPD_R = 8'hF7;
  localparam logic [7:0] c_ERR_V = 8'hFE;
  localparam logic [7:0] c_EXT   = 8'h0F;

  typedef enum logic [3:0] {
    ST_SET    = 4'd0,  // next slot is a set boundary, packet start allowed
    ST_SET_NS = 4'd1,  // set boundary where a packet may not start
    ST_IDLE_D = 4'd2,
    ST_CFG1   = 4'd3,
    ST_CFG2   = 4'd4,
    ST_CFG3   = 4'd5,
    ST_PKT    = 4'd6,
    ST_T_R    = 4'd7,
    ST_EXT_R  = 4'd8,
    ST_EXT_V  = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic        even_q;
  logic [7:0]  code_q, code_d;
  logic        ctrl_q, ctrl_d;
  logic        trans_q, trans_d;
  logic [15:0] cfg_q, cfg_d;
  logic        c2_q, c2_d;
  logic        disp_q, disp_d;
  logic        w_boundary;
  logic        w_allow_s;

  always_comb begin
    state_d    = state_q;
    code_d     = c_K28_5;
    ctrl_d     = 1'b1;
    trans_d    = 1'b0;
    cfg_d      = cfg_q;
    c2_d       = c2_q;
    disp_d     = disp_q;
    w_boundary = 1'b0;
    w_allow_s  = 1'b0;

    case (state_q)
      ST_SET: begin
        w_boundary = 1'b1;
        w_allow_s  = 1'b1;
      end
      ST_SET_NS: w_boundary = 1'b1;
      ST_IDLE_D: begin
        code_d  = disp_q ? c_D5_6 : c_D16_2;
        ctrl_d  = 1'b0;
        state_d = ST_SET;
      end
      ST_CFG1: begin
        code_d  = c2_q ? c_D2_2 : c_D21_5;
        ctrl_d  = 1'b0;
        state_d = ST_CFG2;
      end
      ST_CFG2: begin
        code_d  = cfg_q[7:0];
        ctrl_d  = 1'b0;
        state_d = ST_CFG3;
      end
      ST_CFG3: begin
        code_d  = cfg_q[15:8];
        ctrl_d  = 1'b0;
        c2_d    = ~c2_q;
        state_d = ST_SET;
      end
      ST_PKT: begin
        trans_d = 1'b1;
        if (bus.i_TxEN) begin
          code_d = bus.i_TxER ? c_ERR_V : bus.i8_TxD;
          ctrl_d = bus.i_TxER;
        end else begin
          code_d  = c_EPD_T;
          state_d = ST_T_R;
        end
      end
      ST_T_R: begin
        code_d  = c_EPD_R;
        state_d = ST_EXT_R;
      end
      ST_EXT_R, ST_EXT_V: begin
        if (bus.i_TxER) begin
          if ((state_q == ST_EXT_R) && (bus.i8_TxD == c_EXT)) begin
            code_d = c_EPD_R;
          end else begin
            code_d  = c_ERR_V;
            state_d = ST_EXT_V;
          end
        end else if (even_q) begin
          // Last /R/ or /V/ sat in an even slot: pad so the next K28.5 lands even.
          code_d  = c_EPD_R;
          state_d = ST_SET_NS;
        end else begin
          w_boundary = 1'b1;
        end
      end
      default: w_boundary = 1'b1;
    endcase

    if (w_boundary) begin
      if (w_allow_s && (bus.i3_Xmit == c_XMIT_DATA) && bus.i_TxEN) begin
        code_d  = c_SPD;
        trans_d = 1'b1;
        state_d = ST_PKT;
      end else if (bus.i3_Xmit == c_XMIT_CONFIG) begin
        cfg_d   = bus.i16_TxConfigReg;
        state_d = ST_CFG1;
      end else begin
        // IDLE, DATA without a frame, and any unused encoding all send /I/.
        disp_d  = bus.i_TxDisparity;
        state_d = ST_IDLE_D;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_ARst_L) begin
      state_q <= ST_SET_NS;
      even_q  <= 1'b0;
      code_q  <= c_D16_2;
      ctrl_q  <= 1'b0;
      trans_q <= 1'b0;
      cfg_q   <= '0;
      c2_q    <= 1'b0;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      even_q  <= ~even_q;
      code_q  <= code_d;
      ctrl_q  <= ctrl_d;
      trans_q <= trans_d;
      cfg_q   <= cfg_d;
      c2_q    <= c2_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.o8_TxCodeGroup = code_q;
  assign bus.o_TxCodeCtrl   = ctrl_q;
  assign bus.o_TxEven       = even_q;
  assign bus.o_Transmitting = trans_q;

  // c_XMIT_IDLE documents the encoding; it needs no explicit decode.
  logic w_unused_idle;
  assign w_unused_idle = ^c_XMIT_IDLE;

endmodule

`default_nettype wire

// File: doc/m_transmit.md
M_TRANSMIT -- requirements
Module: m_transmit

Interface
REQ-001 SHALL provide: i_Clk  in  1  code-group clock, one code-group per cycle.
REQ-002 SHALL provide: i_ARst_L  in  1  synchronous, active-low reset, sampled on rising i_Clk.
REQ-003 SHALL provide: i8_TxD  in  8  GMII transmit data.
REQ-004 SHALL provide: i_TxEN  in  1  GMII transmit enable.
REQ-005 SHALL provide: i_TxER  in  1  GMII transmit error / carrier-extend request.
REQ-006 SHALL provide: i3_Xmit  in  3  PCS xmit mode; encodings cXmitCONFIG / cXmitIDLE / cXmitDATA from SGMIIDefs.v.
REQ-007 SHALL provide: i16_TxConfigReg  in  16  auto-negotiation config word.
REQ-008 SHALL provide: i_TxDisparity  in  1  encoder running disparity (1 = positive).
REQ-009 SHALL provide: o8_TxCodeGroup  out  8  unencoded code-group to the 8b/10b encoder.
REQ-010 SHALL provide: o_TxCodeCtrl  out  1  1 = K code-group, 0 = D code-group.
REQ-011 SHALL provide: o_TxEven  out  1  1 = current output slot is even.
REQ-012 SHALL provide: o_Transmitting  out  1  packet in progress.

Function
REQ-013 All outputs SHALL be registered; each output reflects the inputs sampled one cycle earlier (latency 1).
REQ-014 o_TxEven SHALL toggle every cycle after reset; no state may stall it.
REQ-015 Code values SHALL be: K28.5=BC, D21.5=B5, D2.2=42, D5.6=C5, D16.2=50, /S/=K27.7 FB, /T/=K29.7 FD, /R/=K23.7 F7, /V/=K30.7 FE.
REQ-016 Every ordered set SHALL start with K28.5 in an even slot.
REQ-017 i3_Xmit SHALL be sampled only at ordered-set boundaries outside a packet; a change mid-set SHALL take effect at the next boundary.
REQ-018 CONFIG mode SHALL alternate /C1/ = BC,B5,lo,hi and /C2/ = BC,42,lo,hi, with lo/hi = i16_TxConfigReg[7:0]/[15:8] latched in the BC slot; /C1/ SHALL follow reset.
REQ-019 IDLE slot pair SHALL be BC, then C5 if i_TxDisparity=1 at the BC slot (/I1/), else 50 (/I2/).
REQ-020 In IDLE mode i_TxEN SHALL be ignored.
REQ-021 In DATA mode, when the next slot is even and i_TxEN=1, the module SHALL emit /S/; the i8_TxD byte of that cycle is dropped.
REQ-022 In DATA mode, if i_TxEN rises while the next slot is odd, the module SHALL complete the idle D code-group, then emit /S/; both preamble bytes from those two cycles are dropped.
REQ-023 After /S/, while i_TxEN=1: i_TxER=0 -> i8_TxD as D code-group; i_TxER=1 -> /V/.
REQ-024 On the first cycle with i_TxEN=0 the module SHALL emit /T/, then /R/, in either parity.
REQ-025 After an /R/: if i_TxER=1 and i8_TxD=0F, the module SHALL emit /R/ again (carrier extension).
REQ-026 After an /R/: if i_TxER=1 and i8_TxD!=0F, the module SHALL emit /V/ each cycle while i_TxER=1, then follow the REQ-027 alignment rule.
REQ-027 After an /R/: if extension has ended and that /R/ or /V/ was in an even slot, the module SHALL emit one more /R/; otherwise it SHALL resume BC in the even slot.
REQ-028 A packet SHALL NOT be started in the slot immediately following EPD; i_TxEN=1 there SHALL be treated per REQ-022.
REQ-029 o_Transmitting SHALL be 1 from the /S/ cycle through the /T/ cycle inclusive, and 0 otherwise.
REQ-030 Unused or illegal i3_Xmit encodings SHALL be treated as IDLE.

Reset
REQ-031 While i_ARst_L=0 at a clock edge, outputs SHALL load o8_TxCodeGroup=50, o_TxCodeCtrl=0, o_TxEven=0, o_Transmitting=0, and the config alternation SHALL reset to /C1/.
REQ-032 The first output after reset release SHALL be BC with o_TxEven=1.
REQ-033 Reset mid-packet SHALL abort the packet immediately, with no /T/R/ emitted.

Verification
REQ-034 Config sequence: Xmit=CONFIG, cfg=4001 -> BC B5 01 40 BC 42 01 40 repeating; ctrl=1,0,0,0 per set; BC always with o_TxEven=1.
REQ-035 Idle disparity: Xmit=IDLE, i_TxDisparity=1 then 0 -> BC C5 then BC 50.
REQ-036 Even-aligned packet: TxEN rises before an even slot, TxD 55 55 D5 A1 A2, then TxEN=0 -> FB 55 D5 A1 A2 FD F7 F7 BC (second F7 from the even-slot rule); o_Transmitting high FB..FD.
REQ-037 Odd-aligned start plus error: TxEN rises before an odd slot -> C5/50, FB; TxER=1 for one byte mid-frame -> FE in that slot only.
REQ-038 Carrier extension: after frame, TxEN=0, TxER=1, TxD=0F for 3 cycles -> FD F7 F7 F7, then F7 if needed so the next BC is even; TxD=1F during extension -> FE.
REQ-039 Mode switch plus reset: Xmit CONFIG->DATA mid-/C2/ -> /C2/ completes, then idles; i_ARst_L=0 mid-frame -> next output 50 with o_Transmitting=0, then BC with o_TxEven=1.
